result_uart_tx: RTL

- Return-path serializer for the glitch target pipeline.
- Accepts the registered data byte and data-valid strobe from the pipeline stage output, buffers bytes in a small FIFO, and transmits each byte as an 8N1 UART frame on a single TX line back to the host.
- Closes the UART loop: host bytes go in through the RX side, and glitched results come out here.

---
 rtl/result_uart_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: byte FIFO feeding an 8N1 UART transmitter; ports glitched_clk/rst in, DV_2/sum byte strobe in, tx/busy/overflow/fifo_count out
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          glitched_clk,
  input  logic                          rst,
  input  logic                          DV_2,
  input  logic [7:0]                    sum,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [1:0] rst_sync_q;
  logic rst_i;
  state_t state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic baud_end, empty, full, pop, push;
  always_ff @(posedge glitched_clk or posedge rst)
    if (rst) rst_sync_q <= 2'b11;
    else rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign rst_i = rst_sync_q[1];
  assign baud_end = baud_q == BAUD_MAX;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && baud_end));
  // a pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign push = DV_2 && (!full || pop);
  always_ff @(posedge glitched_clk or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  always_ff @(posedge glitched_clk)
    if (push) mem[wr_q] <= sum;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : START;
      START:   state_d = baud_end ? DATA : START;
      DATA:    state_d = (baud_end && bit_q == 3'd7) ? STOP : DATA;
      default: state_d = baud_end ? (empty ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (pop) begin
      shift_d = mem[rd_q];
      tx_d    = 1'b0;
    end else if (state_q == START && baud_end) begin
      tx_d  = shift_q[0];
      bit_d = '0;
    end else if (state_q == DATA && baud_end) begin
      shift_d = shift_q >> 1;
      tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
      bit_d   = bit_q + 3'd1;
    end
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = ovf_q | (DV_2 && !push);
  end
  assign tx = tx_q;
  assign busy = (state_q != IDLE) | !empty;
  assign overflow = ovf_q;
  assign fifo_count = cnt_q;
endmodule
